// File: rtl/maple_pkg.sv
// Shared constants for the Maple frame receiver: FSM state encodings, error codes, header size.
package maple_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_HDR      = 3'd1;
   localparam logic [2:0] ST_PAYLOAD  = 3'd2;
   localparam logic [2:0] ST_CRC      = 3'd3;
   localparam logic [2:0] ST_WAIT_END = 3'd4;

   // Numeric order doubles as reporting priority: ABORT > LEN > CRC.
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_CRC   = 2'd1;
   localparam logic [1:0] ERR_LEN   = 2'd2;
   localparam logic [1:0] ERR_ABORT = 2'd3;

   localparam int MAPLE_HDR_BYTES = 4;

endpackage

// File: rtl/maple_word_fifo.sv
// 32-bit synchronous payload FIFO; extra pointer MSB separates full from empty.
module maple_word_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [31:0] push_data,
   input  logic        pop,
   output logic [31:0] pop_data,
   output logic        full,
   output logic        empty
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [31:0] mem_q [FIFO_DEPTH];
   logic        push_ok, pop_ok;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

   assign pop_data = empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/maple_frame_rx.sv
// Maple bus frame parser: header, payload words into a FIFO, XOR checksum, per-frame status.
// Optional MAPLE_RX_STATS_EN adds saturating ok/error frame counters.
module maple_frame_rx
   import maple_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_det,
   input  logic        end_det,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        hdr_valid,
   output logic [7:0]  hdr_len,
   output logic [7:0]  hdr_src,
   output logic [7:0]  hdr_dst,
   output logic [7:0]  hdr_cmd,
   output logic [31:0] word_data,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        frame_done,
   output logic [1:0]  err_code,
   output logic        overflow
`ifdef MAPLE_RX_STATS_EN
   ,
   output logic [15:0] stat_ok,
   output logic [15:0] stat_err
`endif
);
   logic [2:0]  state_q, state_d, st;
   logic        start_prev_q, start_prev_d, end_prev_q, end_prev_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  word_cnt_q, word_cnt_d;
   logic [23:0] sr_q, sr_d;
   logic [7:0]  acc_q, acc_d;
   logic [1:0]  err_lat_q, err_lat_d;
   logic        ovf_q, ovf_d;
   logic        hdr_valid_q, hdr_valid_d;
   logic [7:0]  len_q, len_d, src_q, src_d, dst_q, dst_d, cmd_q, cmd_d;
   logic        done_q, done_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        start_edge, end_edge, push, pop, fifo_full, fifo_empty;
   logic [31:0] byte_word;

   assign start_edge = start_det && !start_prev_q;
   assign end_edge   = end_det && !end_prev_q;
   assign byte_word  = {sr_q, byte_data};
   assign pop        = word_ready && !fifo_empty;

   always_comb begin
      state_d      = state_q;
      st           = state_q;
      start_prev_d = start_det;
      end_prev_d   = end_det;
      byte_cnt_d   = byte_cnt_q;
      word_cnt_d   = word_cnt_q;
      sr_d         = sr_q;
      acc_d        = acc_q;
      err_lat_d    = err_lat_q;
      ovf_d        = ovf_q;
      hdr_valid_d  = 1'b0;
      len_d        = len_q;
      src_d        = src_q;
      dst_d        = dst_q;
      cmd_d        = cmd_q;
      done_d       = 1'b0;
      err_code_d   = err_code_q;
      push         = 1'b0;

      if (start_edge) begin
         // A new start always wins: close any open frame as aborted and restart parsing.
         if (state_q != ST_IDLE) begin
            done_d     = 1'b1;
            err_code_d = ERR_ABORT;
         end
         state_d    = ST_HDR;
         byte_cnt_d = '0;
         word_cnt_d = '0;
         acc_d      = '0;
         err_lat_d  = ERR_NONE;
         ovf_d      = 1'b0;
      end else begin
         if (byte_valid) begin
            case (state_q)
               ST_HDR, ST_PAYLOAD: begin
                  acc_d      = acc_q ^ byte_data;
                  sr_d       = byte_word[23:0];
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'(MAPLE_HDR_BYTES - 1)) begin
                     if (state_q == ST_HDR) begin
                        {len_d, src_d, dst_d, cmd_d} = byte_word;
                        hdr_valid_d = 1'b1;
                        word_cnt_d  = '0;
                        st          = (byte_word[31:24] == 8'd0) ? ST_CRC : ST_PAYLOAD;
                     end else begin
                        push       = 1'b1;
                        word_cnt_d = word_cnt_q + 8'd1;
                        if (word_cnt_q + 8'd1 == len_q) st = ST_CRC;
                     end
                  end
               end
               ST_CRC: begin
                  if (byte_data != acc_q) err_lat_d = ERR_CRC;
                  st = ST_WAIT_END;
               end
               ST_WAIT_END: err_lat_d = ERR_LEN;
               default: ;
            endcase
         end
         state_d = st;
         if (push && fifo_full && !pop) ovf_d = 1'b1;

         // End is evaluated against the state after this cycle's byte.
         if (end_edge && st != ST_IDLE) begin
            done_d     = 1'b1;
            err_code_d = (st == ST_WAIT_END) ? err_lat_d : ERR_LEN;
            state_d    = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         end_prev_q   <= 1'b0;
         byte_cnt_q   <= '0;
         word_cnt_q   <= '0;
         sr_q         <= '0;
         acc_q        <= '0;
         err_lat_q    <= ERR_NONE;
         ovf_q        <= 1'b0;
         hdr_valid_q  <= 1'b0;
         len_q        <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         cmd_q        <= '0;
         done_q       <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         end_prev_q   <= end_prev_d;
         byte_cnt_q   <= byte_cnt_d;
         word_cnt_q   <= word_cnt_d;
         sr_q         <= sr_d;
         acc_q        <= acc_d;
         err_lat_q    <= err_lat_d;
         ovf_q        <= ovf_d;
         hdr_valid_q  <= hdr_valid_d;
         len_q        <= len_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         cmd_q        <= cmd_d;
         done_q       <= done_d;
         err_code_q   <= err_code_d;
      end
   end

   maple_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (byte_word),
      .pop       (pop),
      .pop_data  (word_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign word_valid = !fifo_empty;
   assign hdr_valid  = hdr_valid_q;
   assign hdr_len    = len_q;
   assign hdr_src    = src_q;
   assign hdr_dst    = dst_q;
   assign hdr_cmd    = cmd_q;
   assign frame_done = done_q;
   assign err_code   = err_code_q;
   assign overflow   = ovf_q;

`ifdef MAPLE_RX_STATS_EN
   logic [15:0] stat_ok_q, stat_ok_d, stat_err_q, stat_err_d;

   always_comb begin
      stat_ok_d  = stat_ok_q;
      stat_err_d = stat_err_q;
      if (done_q) begin
         if (err_code_q == ERR_NONE) begin
            if (stat_ok_q != 16'hFFFF) stat_ok_d = stat_ok_q + 16'd1;
         end else begin
            if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ok_q  <= '0;
         stat_err_q <= '0;
      end else begin
         stat_ok_q  <= stat_ok_d;
         stat_err_q <= stat_err_d;
      end
   end

   assign stat_ok  = stat_ok_q;
   assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_maple_frame_rx.sv
// Directed bench for maple_frame_rx: table of whole frames plus hand sequences for FIFO/abort/reset corners.
module tb_maple_frame_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_det, end_det, byte_valid, word_ready;
   logic [7:0]  byte_data;
   logic        hdr_valid, word_valid, frame_done, overflow;
   logic [7:0]  hdr_len, hdr_src, hdr_dst, hdr_cmd;
   logic [31:0] word_data;
   logic [1:0]  err_code;
`ifdef MAPLE_RX_STATS_EN
   logic [15:0] stat_ok, stat_err;
`endif

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int n_ok = 0;
   int n_err = 0;
   logic [1:0]  last_err = 2'd0;
   logic [7:0]  acc;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   maple_frame_rx #(.FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_det  (start_det),
      .end_det    (end_det),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .hdr_valid  (hdr_valid),
      .hdr_len    (hdr_len),
      .hdr_src    (hdr_src),
      .hdr_dst    (hdr_dst),
      .hdr_cmd    (hdr_cmd),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_done (frame_done),
      .err_code   (err_code),
      .overflow   (overflow)
`ifdef MAPLE_RX_STATS_EN
      ,
      .stat_ok    (stat_ok),
      .stat_err   (stat_err)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor on the falling edge: frame status pulses and popped words against the expected queue.
   always @(negedge clk) begin
      if (rst) begin
         n_ok  = 0;
         n_err = 0;
      end else begin
         if (frame_done) begin
            done_cnt++;
            last_err = err_code;
            if (err_code == 2'd0) n_ok++; else n_err++;
         end
         if (word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL pop_unexpected: got %08h expected none", word_data);
            end else if (word_data !== exp_q[0]) begin
               failures++;
               $display("FAIL pop_word: got %08h expected %08h", word_data, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b);
      tick();
      byte_valid = 1'b1;
      byte_data  = b;
      acc        = acc ^ b;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic send_hdr(input logic [7:0] len, input logic [7:0] src, input logic [7:0] dst, input logic [7:0] cmd);
      send_byte(len); send_byte(src); send_byte(dst); send_byte(cmd);
   endtask

   task automatic start_frame();
      tick();
      start_det = 1'b1;
      acc       = 8'd0;
      tick();
      tick();
      start_det = 1'b0;
   endtask

   task automatic end_frame();
      tick();
      end_det = 1'b1;
      tick();
      tick();
      end_det = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] word_of(input int k);
      return {8'(k), 8'hA5, 8'h3C, 8'(k * 3)};
   endfunction

   typedef struct packed {
      logic [127:0] bytes;
      logic [7:0]   n;
      logic [7:0]   len;
      logic [7:0]   dst;
      logic [7:0]   cmd;
      logic [1:0]   err;
      logic [1:0]   nw;
      logic [63:0]  words;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int d0;
      logic [7:0] c;

      // Frames with bytes left-justified; checksums hand-computed as XOR of header+payload bytes.
      vecs[0] = '{bytes:128'h01002001_DEADBEEF_02000000_00000000, n:8'd9,  len:8'h01, dst:8'h20, cmd:8'h01, err:2'd0, nw:2'd1, words:64'hDEADBEEF_00000000};
      vecs[1] = '{bytes:128'h01002001_DEADBEEF_03000000_00000000, n:8'd9,  len:8'h01, dst:8'h20, cmd:8'h01, err:2'd1, nw:2'd1, words:64'hDEADBEEF_00000000};
      vecs[2] = '{bytes:128'h02002001_DEADBEEF_67000000_00000000, n:8'd9,  len:8'h02, dst:8'h20, cmd:8'h01, err:2'd2, nw:2'd1, words:64'hDEADBEEF_00000000};
      vecs[3] = '{bytes:128'h00052003_26000000_00000000_00000000, n:8'd5,  len:8'h00, dst:8'h20, cmd:8'h03, err:2'd0, nw:2'd0, words:64'h0};
      vecs[4] = '{bytes:128'h02002001_11223344_A55A0FF0_67000000, n:8'd13, len:8'h02, dst:8'h20, cmd:8'h01, err:2'd0, nw:2'd2, words:64'h11223344_A55A0FF0};
      vecs[5] = '{bytes:128'h01002001_DEADBEEF_02770000_00000000, n:8'd10, len:8'h01, dst:8'h20, cmd:8'h01, err:2'd2, nw:2'd1, words:64'hDEADBEEF_00000000};

      rst = 1'b1; start_det = 1'b0; end_det = 1'b0; byte_valid = 1'b0;
      byte_data = 8'd0; word_ready = 1'b0; acc = 8'd0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_outputs", {26'd0, hdr_valid, hdr_len, hdr_src, hdr_dst, hdr_cmd, word_valid, frame_done, err_code, overflow}, 64'd0);
      check("reset_word_data", {32'd0, word_data}, 64'd0);

      // Table of complete frames, consumer always ready.
      word_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         for (int w = 0; w < int'(vecs[v].nw); w++) exp_q.push_back(w == 0 ? vecs[v].words[63:32] : vecs[v].words[31:0]);
         d0 = done_cnt;
         start_frame();
         for (int i = 0; i < int'(vecs[v].n); i++) begin
            send_byte(vecs[v].bytes[127 - 8*i -: 8]);
            if (i == 3) check($sformatf("v%0d_hdr_valid_timing", v), {63'd0, hdr_valid}, 64'd1);
         end
         end_frame();
         check($sformatf("v%0d_hdr_len", v), {56'd0, hdr_len}, {56'd0, vecs[v].len});
         check($sformatf("v%0d_hdr_dst", v), {56'd0, hdr_dst}, {56'd0, vecs[v].dst});
         check($sformatf("v%0d_hdr_cmd", v), {56'd0, hdr_cmd}, {56'd0, vecs[v].cmd});
         check($sformatf("v%0d_done_count", v), 64'(done_cnt - d0), 64'd1);
         check($sformatf("v%0d_err", v), {62'd0, last_err}, {62'd0, vecs[v].err});
         repeat (3) tick();
         check($sformatf("v%0d_drained", v), 64'(exp_q.size()), 64'd0);
      end

      // Overflow: 10 words into 8 slots with no consumer.
      word_ready = 1'b0;
      d0 = done_cnt;
      start_frame();
      send_hdr(8'h0A, 8'h00, 8'h20, 8'h01);
      for (int k = 0; k < 10; k++) begin
         send_word(word_of(k));
         if (k < 8) exp_q.push_back(word_of(k));
         if (k == 0) begin
            check("ovf_word_valid_timing", {63'd0, word_valid}, 64'd1);
            check("ovf_head_word", {32'd0, word_data}, {32'd0, word_of(0)});
         end
      end
      c = acc;
      send_byte(c);
      end_frame();
      check("ovf_overflow_set", {63'd0, overflow}, 64'd1);
      check("ovf_done", 64'(done_cnt - d0), 64'd1);
      check("ovf_err", {62'd0, last_err}, 64'd0);
      word_ready = 1'b1;
      repeat (10) tick();
      check("ovf_drain_all", 64'(exp_q.size()), 64'd0);
      check("ovf_empty_after", {63'd0, word_valid}, 64'd0);

      // Full FIFO with push and pop on the same edge: no drop.
      word_ready = 1'b0;
      start_frame();
      check("ovf_cleared_on_start", {63'd0, overflow}, 64'd0);
      send_hdr(8'h09, 8'h00, 8'h20, 8'h01);
      for (int k = 0; k < 9; k++) exp_q.push_back(word_of(k));
      for (int k = 0; k < 8; k++) send_word(word_of(k));
      send_byte(word_of(8)[31:24]);
      send_byte(word_of(8)[23:16]);
      send_byte(word_of(8)[15:8]);
      tick();
      byte_valid = 1'b1;
      byte_data  = word_of(8)[7:0];
      acc        = acc ^ byte_data;
      word_ready = 1'b1;
      tick();
      byte_valid = 1'b0;
      word_ready = 1'b0;
      c = acc;
      send_byte(c);
      end_frame();
      check("full_pushpop_no_overflow", {63'd0, overflow}, 64'd0);
      check("full_pushpop_err", {62'd0, last_err}, 64'd0);
      word_ready = 1'b1;
      repeat (12) tick();
      check("full_pushpop_drain", 64'(exp_q.size()), 64'd0);

      // Start edge mid-payload aborts, then the new frame parses cleanly.
      start_frame();
      send_hdr(8'h01, 8'h00, 8'h20, 8'h01);
      send_byte(8'hDE);
      send_byte(8'hAD);
      d0 = done_cnt;
      start_frame();
      check("abort_done", 64'(done_cnt - d0), 64'd1);
      check("abort_err", {62'd0, last_err}, 64'd3);
      exp_q.push_back(32'hDEADBEEF);
      send_hdr(8'h01, 8'h00, 8'h20, 8'h01);
      send_word(32'hDEADBEEF);
      c = acc;
      send_byte(c);
      end_frame();
      check("after_abort_done", 64'(done_cnt - d0), 64'd2);
      check("after_abort_err", {62'd0, last_err}, 64'd0);
      check("after_abort_overflow", {63'd0, overflow}, 64'd0);
      repeat (3) tick();
      check("after_abort_drain", 64'(exp_q.size()), 64'd0);

      // Checksum byte and end edge in the same cycle.
      d0 = done_cnt;
      exp_q.push_back(32'hDEADBEEF);
      start_frame();
      send_hdr(8'h01, 8'h00, 8'h20, 8'h01);
      send_word(32'hDEADBEEF);
      tick();
      byte_valid = 1'b1;
      byte_data  = 8'h02;
      end_det    = 1'b1;
      tick();
      byte_valid = 1'b0;
      tick();
      end_det = 1'b0;
      tick();
      check("same_cycle_end_done", 64'(done_cnt - d0), 64'd1);
      check("same_cycle_end_err", {62'd0, last_err}, 64'd0);
      check("same_cycle_end_drain", 64'(exp_q.size()), 64'd0);

      // Reset mid-payload: outputs cleared immediately, no frame_done, then normal operation.
      word_ready = 1'b0;
      start_frame();
      send_hdr(8'h02, 8'h00, 8'h20, 8'h01);
      send_word(32'h01020304);
      send_byte(8'h55);
      d0 = done_cnt;
      #1;
      rst = 1'b1;
      #1;
      check("rst_outputs", {26'd0, hdr_valid, hdr_len, hdr_src, hdr_dst, hdr_cmd, word_valid, frame_done, err_code, overflow}, 64'd0);
      check("rst_word_data", {32'd0, word_data}, 64'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("rst_no_done", 64'(done_cnt - d0), 64'd0);
      word_ready = 1'b1;
      exp_q.push_back(32'hDEADBEEF);
      start_frame();
      send_hdr(8'h01, 8'h00, 8'h20, 8'h01);
      send_word(32'hDEADBEEF);
      c = acc;
      send_byte(c);
      end_frame();
      check("post_rst_done", 64'(done_cnt - d0), 64'd1);
      check("post_rst_err", {62'd0, last_err}, 64'd0);
      check("post_rst_len", {56'd0, hdr_len}, 64'd1);
      repeat (3) tick();
      check("post_rst_drain", 64'(exp_q.size()), 64'd0);

`ifdef MAPLE_RX_STATS_EN
      check("stat_ok", {48'd0, stat_ok}, 64'(n_ok));
      check("stat_err", {48'd0, stat_err}, 64'(n_err));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
